serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 120 ++++++++++++
 tb/tb_serial_subtractor.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b LSB-first, one bit per clock,
// using two chained half-subtractors per bit and a registered borrow.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] aSr_q;
    logic [WIDTH-1:0] bSr_q;
    logic [WIDTH-1:0] resSr_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrowBit_q;
    logic             borrow_q;
    logic             busy_q;
    logic             done_q;
    logic [CW-1:0]    count_q;

    logic [WIDTH-1:0] resSr_d;
    logic             bit_d;
    logic             borrowBit_d;
    logic             d1;
    logic             b1;
    logic             b2;

    // Half-subtractor on the operand bits, then a second one folding in the borrow.
    always_comb begin
        d1          = aSr_q[0] ^ bSr_q[0];
        b1          = ~aSr_q[0] & bSr_q[0];
        bit_d       = d1 ^ borrowBit_q;
        b2          = ~d1 & borrowBit_q;
        borrowBit_d = b1 | b2;
    end

    generate
        if (WIDTH == 1) begin : gSingle
            assign resSr_d = bit_d;
        end else begin : gMulti
            assign resSr_d = {bit_d, resSr_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            aSr_q       <= '0;
            bSr_q       <= '0;
            resSr_q     <= '0;
            diff_q      <= '0;
            borrowBit_q <= 1'b0;
            borrow_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        aSr_q       <= a;
                        bSr_q       <= b;
                        resSr_q     <= '0;
                        borrowBit_q <= 1'b0;
                        count_q     <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= SHIFT;
                    end
                end
                SHIFT: begin
                    aSr_q       <= aSr_q >> 1;
                    bSr_q       <= bSr_q >> 1;
                    resSr_q     <= resSr_d;
                    borrowBit_q <= borrowBit_d;
                    count_q     <= count_q + 1'b1;
                    // Last bit: publish the full result straight from the next-state value.
                    if (count_q == LAST_BIT) begin
                        diff_q   <= resSr_d;
                        borrow_q <= borrowBit_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit instance for timing and handshake
// checks plus a 4-bit instance swept over every operand pair.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rstN;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic [7:0] diff8;
    logic       borrow8;
    logic       busy8;
    logic       done8;
    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic [3:0] diff4;
    logic       borrow4;
    logic       busy4;
    logic       done4;

    logic [8:0] expQ8[$];
    logic [4:0] expQ4[$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rstN), .start(start8), .a(a8), .b(b8),
        .diff(diff8), .borrow(borrow8), .busy(busy8), .done(done8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rstN), .start(start4), .a(a4), .b(b4),
        .diff(diff4), .borrow(borrow4), .busy(busy4), .done(done4)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one start pulse from IDLE and optionally records the expected result.
    task automatic applyStimulus(input logic [7:0] aIn, input logic [7:0] bIn, input bit push);
        logic [7:0] expDiff;
        expDiff = aIn - bIn;
        start8 = 1'b1;
        a8     = aIn;
        b8     = bIn;
        if (push) expQ8.push_back({aIn < bIn, expDiff});
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic waitDone8(output int latency, output int busyCount);
        latency   = 0;
        busyCount = busy8 ? 1 : 0;
        while (!done8 && latency < 40) begin
            @(negedge clk);
            latency++;
            if (busy8) busyCount++;
        end
        if (!done8) checkOutput("done8Timeout", {31'd0, done8}, 32'd1);
    endtask

    task automatic checkResult8(input string tag);
        logic [8:0] expVal;
        checkOutput({tag, "_queue"}, {31'd0, expQ8.size() > 0}, 32'd1);
        expVal = (expQ8.size() > 0) ? expQ8.pop_front() : 9'h1ff;
        checkOutput({tag, "_diff"}, {24'd0, diff8}, {24'd0, expVal[7:0]});
        checkOutput({tag, "_borrow"}, {31'd0, borrow8}, {31'd0, expVal[8]});
    endtask

    task automatic runOp8(input logic [7:0] aIn, input logic [7:0] bIn, input string tag);
        int lat;
        int bc;
        applyStimulus(aIn, bIn, 1'b1);
        waitDone8(lat, bc);
        checkResult8(tag);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int bc;
        int doneCount;
        int lastDone;
        bit sawDone;
        bit sawBusy;

        rstN   = 1'b0;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        start4 = 1'b0;
        a4     = '0;
        b4     = '0;
        repeat (2) @(negedge clk);
        checkOutput("resetDiff", {24'd0, diff8}, 32'd0);
        checkOutput("resetBorrow", {31'd0, borrow8}, 32'd0);
        checkOutput("resetBusy", {31'd0, busy8}, 32'd0);
        checkOutput("resetDone", {31'd0, done8}, 32'd0);
        checkOutput("resetDiff4", {28'd0, diff4}, 32'd0);
        rstN = 1'b1;
        @(negedge clk);

        $display("[TB] basic 200-55 with latency and busy window");
        applyStimulus(8'd200, 8'd55, 1'b1);
        checkOutput("busyAfterStart", {31'd0, busy8}, 32'd1);
        waitDone8(lat, bc);
        checkOutput("latency", lat, 32'd8);
        checkOutput("busyCycles", bc, 32'd8);
        checkResult8("sub200_55");
        @(negedge clk);
        checkOutput("donePulseEnds", {31'd0, done8}, 32'd0);

        $display("[TB] borrow and wrap cases");
        runOp8(8'd5, 8'd10, "sub5_10");
        runOp8(8'd0, 8'd255, "sub0_255");
        runOp8(8'd0, 8'd0, "sub0_0");
        runOp8(8'd255, 8'd255, "sub255_255");

        $display("[TB] start during DONE is ignored");
        applyStimulus(8'd7, 8'd3, 1'b1);
        waitDone8(lat, bc);
        checkResult8("sub7_3");
        start8 = 1'b1;
        a8     = 8'd9;
        b8     = 8'd1;
        @(negedge clk);
        start8  = 1'b0;
        sawDone = 1'b0;
        sawBusy = 1'b0;
        repeat (12) begin
            @(negedge clk);
            sawDone |= done8;
            sawBusy |= busy8;
        end
        checkOutput("doneStartIgnoredBusy", {31'd0, sawBusy}, 32'd0);
        checkOutput("doneStartIgnoredDone", {31'd0, sawDone}, 32'd0);
        checkOutput("doneStartIgnoredDiff", {24'd0, diff8}, 32'd4);

        $display("[TB] start held high, operands scrambled during SHIFT");
        start8 = 1'b1;
        a8     = 8'd100;
        b8     = 8'd1;
        expQ8.push_back({1'b0, 8'd99});
        doneCount = 0;
        lastDone  = -1;
        for (int n = 1; n <= 31; n++) begin
            @(negedge clk);
            if (done8) begin
                doneCount++;
                if (lastDone >= 0) checkOutput("contPeriod", n - lastDone, 32'd10);
                lastDone = n;
                checkResult8("cont");
                a8 = 8'd100;
                b8 = 8'd1;
                expQ8.push_back({1'b0, 8'd99});
            end else if (busy8) begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
        end
        start8 = 1'b0;
        checkOutput("contDoneCount", doneCount, 32'd3);
        waitDone8(lat, bc);
        checkResult8("contTail");
        @(negedge clk);

        $display("[TB] reset in the middle of an operation");
        applyStimulus(8'd50, 8'd20, 1'b0);
        repeat (4) @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        checkOutput("abortDiff", {24'd0, diff8}, 32'd0);
        checkOutput("abortBorrow", {31'd0, borrow8}, 32'd0);
        checkOutput("abortBusy", {31'd0, busy8}, 32'd0);
        checkOutput("abortDone", {31'd0, done8}, 32'd0);
        sawDone = 1'b0;
        repeat (14) begin
            @(negedge clk);
            sawDone |= done8;
        end
        checkOutput("abortNoDone", {31'd0, sawDone}, 32'd0);
        runOp8(8'd50, 8'd20, "sub50_20");

        $display("[TB] exhaustive 4-bit sweep");
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                logic [3:0] ea;
                logic [3:0] eb;
                logic [3:0] ed;
                logic [4:0] expVal;
                int         wait4;
                ea = 4'(ai);
                eb = 4'(bi);
                ed = ea - eb;
                start4 = 1'b1;
                a4     = ea;
                b4     = eb;
                expQ4.push_back({ea < eb, ed});
                @(negedge clk);
                start4 = 1'b0;
                wait4  = 0;
                while (!done4 && wait4 < 20) begin
                    @(negedge clk);
                    wait4++;
                end
                if (!done4) checkOutput("done4Timeout", {31'd0, done4}, 32'd1);
                expVal = expQ4.pop_front();
                checkOutput($sformatf("exh_%0d_%0d", ai, bi), {27'd0, borrow4, diff4}, {27'd0, expVal});
                @(negedge clk);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
